// File: rtl/switch_counter_param.sv
// switch_counter_param
//   Push-button event counter. The raw button is synchronised and debounced.
//   Each accepted press steps a WIDTH-bit count up or down (slideSwitch),
//   either wrapping or saturating at 0 / MAX_COUNT (modeSwitch).
//
// Ports
//   clk         system clock, all state on the rising edge
//   resetN      asynchronous active-low reset
//   pushButton  raw button, active high, may bounce
//   slideSwitch direction: 0 = up, 1 = down
//   modeSwitch  limit mode: 0 = wrap, 1 = saturate
//   LEDS        current count (0..MAX_COUNT)
//   overflow    one-cycle pulse when a step hits a limit (wrap or hold)
//
// Build option
//   AUTO_REPEAT_EN  when defined, a held button auto-repeats: the first repeat
//                   comes REPEAT_DELAY cycles after the press step, then one
//                   every REPEAT_PERIOD cycles. When undefined, REPEAT_* are
//                   ignored and no hold counter exists.
module switch_counter_param #(
    parameter int                WIDTH           = 16,
    parameter logic [WIDTH-1:0]  MAX_COUNT       = '1,
    parameter int                DEBOUNCE_CYCLES = 1000000,
    parameter int                REPEAT_DELAY    = 50000000,
    parameter int                REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             pushButton,
    input  logic             slideSwitch,
    input  logic             modeSwitch,
    output logic [WIDTH-1:0] LEDS,
    output logic             overflow
);

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Two-flop synchronisers, bit order {mode, slide, button}.
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             btn_stable_q, btn_stable_d;
    logic             btn_prev_q, btn_prev_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic btn_sync, dir_down, mode_sat;
    logic press, step;

    assign btn_sync = sync2_q[0];
    assign dir_down = sync2_q[1];
    assign mode_sat = sync2_q[2];

    // Rising edge of the debounced level; releases never produce an event.
    assign press = btn_stable_q & ~btn_prev_q;

`ifdef AUTO_REPEAT_EN
    // hold_cnt is 1 on the cycle after a step and counts up while held;
    // rep_phase selects the first-delay or steady-period threshold.
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic        rep_phase_q, rep_phase_d;
    logic        repeat_fire;

    assign repeat_fire = btn_stable_q && (hold_cnt_q != '0) &&
                         (hold_cnt_q == (rep_phase_q ? 32'(REPEAT_PERIOD)
                                                     : 32'(REPEAT_DELAY)));
    assign step = press | repeat_fire;

    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        rep_phase_d = rep_phase_q;
        if (!btn_stable_q) begin
            hold_cnt_d  = '0;
            rep_phase_d = 1'b0;
        end else if (press) begin
            hold_cnt_d  = 32'd1;
            rep_phase_d = 1'b0;
        end else if (repeat_fire) begin
            hold_cnt_d  = 32'd1;
            rep_phase_d = 1'b1;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d  = hold_cnt_q + 32'd1;
        end
    end
`else
    assign step = press;

    // Repeat parameters exist only for a common parameter list; no hardware.
    if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_repeat_unused
    end
`endif

    always_comb begin
        sync1_d      = {modeSwitch, slideSwitch, pushButton};
        sync2_d      = sync1_q;
        db_cnt_d     = '0;
        btn_stable_d = btn_stable_q;
        btn_prev_d   = btn_stable_q;
        if (btn_sync != btn_stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_stable_d = btn_sync;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_comb begin
        count_d    = count_q;
        overflow_d = 1'b0;
        if (step) begin
            if (!dir_down) begin
                if (count_q >= MAX_COUNT) begin
                    overflow_d = 1'b1;
                    count_d    = mode_sat ? MAX_COUNT : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    overflow_d = 1'b1;
                    count_d    = mode_sat ? '0 : MAX_COUNT;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_cnt_q     <= '0;
            btn_stable_q <= 1'b0;
            btn_prev_q   <= 1'b0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
            hold_cnt_q   <= '0;
            rep_phase_q  <= 1'b0;
`endif
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_cnt_q     <= db_cnt_d;
            btn_stable_q <= btn_stable_d;
            btn_prev_q   <= btn_prev_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
`ifdef AUTO_REPEAT_EN
            hold_cnt_q   <= hold_cnt_d;
            rep_phase_q  <= rep_phase_d;
`endif
        end
    end

    assign LEDS     = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_switch_counter_param.sv
// tb_switch_counter_param
//   Directed bench for switch_counter_param with WIDTH=4, MAX_COUNT=9,
//   DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5. Inputs change and
//   outputs are sampled 1 ns after a rising edge, so "edge N after the
//   button rises" is N calls of tick after driving pushButton.
module tb_switch_counter_param;

    logic       clk = 1'b0;
    logic       resetN;
    logic       pushButton;
    logic       slideSwitch;
    logic       modeSwitch;
    logic [3:0] LEDS;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int exp_cnt;

    switch_counter_param #(
        .WIDTH           (4),
        .MAX_COUNT       (4'd9),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .pushButton  (pushButton),
        .slideSwitch (slideSwitch),
        .modeSwitch  (modeSwitch),
        .LEDS        (LEDS),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: a clean press held `hold` cycles then `gap` cycles low.
    task automatic do_press(input int hold, input int gap);
        pushButton = 1'b1;
        repeat (hold) tick();
        pushButton = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            pushButton = i[0];
            tick();
            total++;
            if (LEDS !== 4'd0 || overflow !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: LEDS=%0d overflow=%b, want 0/0", LEDS, overflow);
            end
        end
        pushButton = 1'b0;
        resetN = 1'b1;
        repeat (12) tick();
        total++;
        if (LEDS !== 4'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: LEDS=%0d overflow=%b, want 0/0", LEDS, overflow);
        end
        exp_cnt = 0;
    endtask

    task automatic test_clean_up();
        logic ov_seen;
        ov_seen = 1'b0;
        for (int p = 0; p < 3; p++) begin
            pushButton = 1'b1;
            repeat (6) begin
                tick();
                ov_seen = ov_seen | overflow;
            end
            total++;
            if (LEDS !== 4'(exp_cnt)) begin
                bad++;
                $display("FAIL clean_early: LEDS=%0d, want %0d", LEDS, exp_cnt);
            end
            tick();
            ov_seen = ov_seen | overflow;
            exp_cnt++;
            total++;
            if (LEDS !== 4'(exp_cnt)) begin
                bad++;
                $display("FAIL clean_edge7: LEDS=%0d, want %0d", LEDS, exp_cnt);
            end
            repeat (3) begin
                tick();
                ov_seen = ov_seen | overflow;
            end
            pushButton = 1'b0;
            repeat (10) begin
                tick();
                ov_seen = ov_seen | overflow;
            end
        end
        total++;
        if (ov_seen !== 1'b0 || LEDS !== 4'd3) begin
            bad++;
            $display("FAIL clean_final: LEDS=%0d ov_seen=%b, want 3/0", LEDS, ov_seen);
        end
    endtask

    task automatic test_bounce();
        // 2-cycle glitch: debounce never completes
        pushButton = 1'b1;
        repeat (2) tick();
        pushButton = 1'b0;
        repeat (12) tick();
        total++;
        if (LEDS !== 4'(exp_cnt)) begin
            bad++;
            $display("FAIL bounce_glitch: LEDS=%0d, want %0d", LEDS, exp_cnt);
        end
        // single-cycle highs at 0,2,4 then held high
        for (int i = 0; i < 4; i++) begin
            pushButton = ~i[0];
            tick();
        end
        pushButton = 1'b1;
        repeat (15) tick();
        pushButton = 1'b0;
        repeat (12) tick();
        exp_cnt++;
        total++;
        if (LEDS !== 4'(exp_cnt)) begin
            bad++;
            $display("FAIL bounce_train: LEDS=%0d, want %0d", LEDS, exp_cnt);
        end
    endtask

    // Press expecting a limit event: result `want`, overflow for one cycle.
    task automatic limit_press(input logic [3:0] want, input string name);
        pushButton = 1'b1;
        repeat (6) tick();
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL %s_pre: overflow=%b, want 0", name, overflow);
        end
        tick();
        total++;
        if (LEDS !== want || overflow !== 1'b1) begin
            bad++;
            $display("FAIL %s_step: LEDS=%0d overflow=%b, want %0d/1", name, LEDS, overflow, want);
        end
        tick();
        total++;
        if (LEDS !== want || overflow !== 1'b0) begin
            bad++;
            $display("FAIL %s_post: LEDS=%0d overflow=%b, want %0d/0", name, LEDS, overflow, want);
        end
        repeat (2) tick();
        pushButton = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_wrap();
        modeSwitch  = 1'b0;
        slideSwitch = 1'b0;
        repeat (9 - exp_cnt) do_press(10, 10);
        total++;
        if (LEDS !== 4'd9) begin
            bad++;
            $display("FAIL wrap_setup: LEDS=%0d, want 9", LEDS);
        end
        limit_press(4'd0, "wrap_up");
        slideSwitch = 1'b1;
        limit_press(4'd9, "wrap_down");
        exp_cnt = 9;
    endtask

    task automatic test_saturate();
        modeSwitch  = 1'b1;
        slideSwitch = 1'b0;
        repeat (4) tick();
        limit_press(4'd9, "sat_up");
        slideSwitch = 1'b1;
        repeat (9) do_press(10, 10);
        total++;
        if (LEDS !== 4'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL sat_down_to_zero: LEDS=%0d overflow=%b, want 0/0", LEDS, overflow);
        end
        limit_press(4'd0, "sat_down");
        exp_cnt = 0;
    endtask

    task automatic test_mid_reset();
        int want;
        slideSwitch = 1'b0;
        repeat (4) tick();
        repeat (4) do_press(10, 10);
        pushButton = 1'b1;
        repeat (7) tick();
        total++;
        if (LEDS !== 4'd5) begin
            bad++;
            $display("FAIL midrst_setup: LEDS=%0d, want 5", LEDS);
        end
        repeat (3) tick();
        resetN = 1'b0;
        #1;
        total++;
        if (LEDS !== 4'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL midrst_immediate: LEDS=%0d overflow=%b, want 0/0", LEDS, overflow);
        end
        repeat (3) tick();
        resetN = 1'b1;
        for (int t = 1; t <= 50; t++) begin
            tick();
`ifdef AUTO_REPEAT_EN
            want = int'(t >= 7) + int'(t >= 27) + int'(t >= 32) + int'(t >= 37) + int'(t >= 42);
`else
            want = int'(t >= 7);
`endif
            total++;
            if (LEDS !== 4'(want)) begin
                bad++;
                $display("FAIL midrst_edge%0d: LEDS=%0d, want %0d", t, LEDS, want);
            end
            if (t == 40) pushButton = 1'b0;
        end
    endtask

    initial begin
        resetN      = 1'b0;
        pushButton  = 1'b0;
        slideSwitch = 1'b0;
        modeSwitch  = 1'b0;
        exp_cnt     = 0;
        test_reset();
        test_clean_up();
        test_bounce();
        test_wrap();
        test_saturate();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
